// File: rtl/fd_dram_bridge_pkg.sv
// Shared types for the FD-to-DRAM bridge: record layout, bridge FSM states
// and the DRAM base address of record 0.
package fd_dram_bridge_pkg;

    localparam logic [16:0] DRAM_BASE = 17'h10000;

    // One OUT_INFO record as stored in DRAM
    typedef struct packed {
        logic [31:0] d_man_info;
        logic [31:0] res_info;
    } OUT_INFO;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW,
        WR_W,
        WR_B,
        DONE
    } Bridge_state;

endpackage

// File: rtl/fd_bridge_cache.sv
// One-entry record cache {vld, tag, data} with hit compare. Used by
// fd_dram_bridge only when FD_BRIDGE_CACHE_EN is defined.
module fd_bridge_cache
    import fd_dram_bridge_pkg::*;
#(
    parameter int DATA_W = $bits(OUT_INFO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        lookup_tag_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              fill_i,
    input  logic [7:0]        fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i
);

    logic              vld_q;
    logic [7:0]        tag_q;
    logic [DATA_W-1:0] data_q;

    // Valid bit and tag: the valid bit alone decides whether the entry is usable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            tag_q <= '0;
        end else if (fill_i) begin
            vld_q <= 1'b1;
            tag_q <= fill_tag_i;
        end
    end

    // Cached record payload
    // NOTE: payload is storage, not control; vld_q guards it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            data_q <= fill_data_i;
        end
    end

    assign hit_o     = vld_q && (tag_q == lookup_tag_i);
    assign rd_data_o = data_q;

endmodule

// File: rtl/fd_dram_bridge.sv
// FD controller to pseudo-DRAM bridge over AXI4-Lite. One outstanding
// request; each read/write becomes a single AXI transaction and completion is
// signalled by a one-cycle C_out_valid pulse. All outputs are registered.
// Optional feature: FD_BRIDGE_CACHE_EN adds a one-entry write-through record
// cache; without it every request goes to DRAM.
module fd_dram_bridge
    import fd_dram_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = $bits(OUT_INFO),
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DRAM_BASE)
) (
    input  logic              clk,
    input  logic              rst_n,
    // FD request side
    input  logic [7:0]        C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    input  logic              C_in_valid,
    input  logic              C_r_wb,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
    // AXI4-Lite read address / data
    output logic              AR_VALID,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              AR_READY,
    input  logic              R_VALID,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              R_READY,
    // AXI4-Lite write address / data / response
    output logic              AW_VALID,
    output logic [ADDR_W-1:0] AW_ADDR,
    input  logic              AW_READY,
    output logic              W_VALID,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              W_READY,
    input  logic              B_VALID,
    input  logic [1:0]        B_RESP,
    output logic              B_READY
);

    Bridge_state       state_q, state_d;
    logic              ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_r_q;

    logic              accept;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rdata;
    logic              hit_take;

    // Responses are assumed OKAY by protocol; they are intentionally not used
    logic              unused_resp;
    assign unused_resp = ^{R_RESP, B_RESP};

    assign accept   = (state_q == IDLE) && C_in_valid;
    assign hit_take = accept && C_r_wb && cache_hit;
    assign ar_hs    = ar_valid_q && AR_READY;
    assign r_hs     = r_ready_q  && R_VALID;
    assign aw_hs    = aw_valid_q && AW_READY;
    assign w_hs     = w_valid_q  && W_READY;
    assign b_hs     = b_ready_q  && B_VALID;

`ifdef FD_BRIDGE_CACHE_EN
    logic [7:0] id_q;

    // Record ID of the request in flight, used as the cache fill tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= '0;
        end else if (accept) begin
            id_q <= C_addr;
        end
    end

    fd_bridge_cache #(
        .DATA_W (DATA_W)
    ) u_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_tag_i (C_addr),
        .hit_o        (cache_hit),
        .rd_data_o    (cache_rdata),
        .fill_i       (r_hs || b_hs),
        .fill_tag_i   (id_q),
        .fill_data_i  (r_hs ? R_DATA : wdata_q)
    );
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = '0;
`endif

    // Next-state logic: one AXI transaction per accepted request
    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (C_in_valid) begin
                    if (!C_r_wb)        state_d = WR_AW;
                    else if (cache_hit) state_d = DONE;
                    else                state_d = RD_AR;
                end
            end
            RD_AR:   if (ar_hs) state_d = RD_R;
            RD_R:    if (r_hs)  state_d = DONE;
            WR_AW:   if (aw_hs) state_d = WR_W;
            WR_W:    if (w_hs)  state_d = WR_B;
            WR_B:    if (b_hs)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered channel strobes decoded from the next state
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= (state_d == RD_AR);
            r_ready_q   <= (state_d == RD_R);
            aw_valid_q  <= (state_d == WR_AW);
            w_valid_q   <= (state_d == WR_W);
            b_ready_q   <= (state_d == WR_B);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Address and write data are captured once at request and held until the handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= BASE_ADDR + ADDR_W'({C_addr, 3'b000});
            wdata_q <= C_data_w;
        end
    end

    // Completion data: read data on R handshake or cache hit, zero after a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_q <= '0;
        end else if (r_hs) begin
            data_r_q <= R_DATA;
        end else if (b_hs) begin
            data_r_q <= '0;
        end else if (hit_take) begin
            data_r_q <= cache_rdata;
        end
    end

    assign AR_VALID    = ar_valid_q;
    assign AR_ADDR     = addr_q;
    assign R_READY     = r_ready_q;
    assign AW_VALID    = aw_valid_q;
    assign AW_ADDR     = addr_q;
    assign W_VALID     = w_valid_q;
    assign W_DATA      = wdata_q;
    assign B_READY     = b_ready_q;
    assign C_out_valid = out_valid_q;
    assign C_data_r    = data_r_q;

endmodule

// File: tb/tb_fd_dram_bridge.sv
// Self-checking bench for fd_dram_bridge: an AXI4-Lite slave model with
// programmable READY/VALID delays backed by a DRAM model, and a scoreboard of
// expected completion data checked whenever C_out_valid pulses.
module tb_fd_dram_bridge;

    localparam logic [16:0] BASE = 17'h10000;

    logic        clk, rst_n;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w;
    logic        C_in_valid, C_r_wb;
    logic        C_out_valid;
    logic [63:0] C_data_r;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [63:0] R_DATA, W_DATA;
    logic [1:0]  R_RESP, B_RESP;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb[$];

    // Slave configuration and statistics
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_count = 0, aw_count = 0, w_count = 0;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int ar_vcycles = 0, w_vcycles = 0;
    bit rd_pend = 0, b_pend = 0, ar_unstable = 0, w_unstable = 0;
    logic [16:0] rd_addr, wr_addr, last_ar_addr, last_aw_addr, ar_first;
    logic [63:0] w_first, last_w_data;

    logic [63:0] mem    [logic [16:0]];
    logic [63:0] golden [logic [7:0]];
`ifdef FD_BRIDGE_CACHE_EN
    bit         c_vld = 0;
    logic [7:0] c_tag = '0;
`endif

    fd_dram_bridge #(
        .ADDR_W    (17),
        .DATA_W    (64),
        .BASE_ADDR (17'h10000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r),
        .AR_VALID    (AR_VALID),
        .AR_ADDR     (AR_ADDR),
        .AR_READY    (AR_READY),
        .R_VALID     (R_VALID),
        .R_DATA      (R_DATA),
        .R_RESP      (R_RESP),
        .R_READY     (R_READY),
        .AW_VALID    (AW_VALID),
        .AW_ADDR     (AW_ADDR),
        .AW_READY    (AW_READY),
        .W_VALID     (W_VALID),
        .W_DATA      (W_DATA),
        .W_READY     (W_READY),
        .B_VALID     (B_VALID),
        .B_RESP      (B_RESP),
        .B_READY     (B_READY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pattern(input logic [16:0] a);
        return {a, 15'h1234, ~a, 15'h0F0F};
    endfunction

    function automatic logic [16:0] rec_addr(input logic [7:0] id);
        return BASE + {6'd0, id, 3'b000};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [16:0] a);
        return mem.exists(a) ? mem[a] : pattern(a);
    endfunction

    function automatic logic [63:0] exp_read(input logic [7:0] id);
        return golden.exists(id) ? golden[id] : pattern(rec_addr(id));
    endfunction

    // AXI4-Lite slave: decides READY/VALID at the falling edge for the next rising edge
    initial begin
        AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 2'b00;
        AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
                rd_pend = 0; b_pend = 0;
                ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                if (rd_pend) begin
                    if (r_wait >= r_delay) begin
                        R_VALID = 1; R_DATA = mem_rd(rd_addr);
                        if (R_READY) rd_pend = 0;
                    end else begin
                        R_VALID = 0; r_wait++;
                    end
                end else R_VALID = 0;

                if (b_pend) begin
                    if (b_wait >= b_delay) begin
                        B_VALID = 1;
                        if (B_READY) b_pend = 0;
                    end else begin
                        B_VALID = 0; b_wait++;
                    end
                end else B_VALID = 0;

                if (AR_VALID) begin
                    if (ar_wait == 0) ar_first = AR_ADDR;
                    else if (AR_ADDR !== ar_first) ar_unstable = 1;
                    ar_vcycles++;
                    if (ar_wait >= ar_delay) begin
                        AR_READY = 1; rd_pend = 1; rd_addr = AR_ADDR; r_wait = 0;
                        ar_wait = 0; ar_count++; last_ar_addr = AR_ADDR;
                    end else begin
                        AR_READY = 0; ar_wait++;
                    end
                end else AR_READY = 0;

                if (AW_VALID) begin
                    if (aw_wait >= aw_delay) begin
                        AW_READY = 1; wr_addr = AW_ADDR; last_aw_addr = AW_ADDR;
                        aw_wait = 0; aw_count++;
                    end else begin
                        AW_READY = 0; aw_wait++;
                    end
                end else AW_READY = 0;

                if (W_VALID) begin
                    if (w_wait == 0) w_first = W_DATA;
                    else if (W_DATA !== w_first) w_unstable = 1;
                    w_vcycles++;
                    if (w_wait >= w_delay) begin
                        W_READY = 1; mem[wr_addr] = W_DATA; last_w_data = W_DATA;
                        b_pend = 1; b_wait = 0; w_wait = 0; w_count++;
                    end else begin
                        W_READY = 0; w_wait++;
                    end
                end else W_READY = 0;
            end
        end
    end

    // Scoreboard monitor: every completion pops one expected record
    initial begin
        logic [63:0] exp;
        bit prev_ov;
        prev_ov = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (C_out_valid) begin
                    checks++;
                    if (prev_ov) begin
                        failures++;
                        $display("FAIL out_valid_width: C_out_valid high 2 cycles, required 1");
                    end else if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_completion: C_out_valid=1 with no request outstanding");
                    end else begin
                        exp = sb.pop_front();
                        if (C_data_r !== exp) begin
                            failures++;
                            $display("FAIL C_data_r: got %h expected %h", C_data_r, exp);
                        end
                    end
                end
                if (AW_VALID || W_VALID) begin
                    checks++;
                    if (AW_VALID && W_VALID) begin
                        failures++;
                        $display("FAIL aw_w_concurrent: AW_VALID=1 W_VALID=1, required exclusive");
                    end
                end
            end
            prev_ov = rst_n && C_out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input bit rd, input logic [7:0] id, input logic [63:0] data);
        C_addr = id; C_data_w = data; C_r_wb = rd; C_in_valid = 1;
        @(negedge clk);
        C_in_valid = 0;
    endtask

    // One request from IDLE to completion; lat counts cycles after the request cycle (-1 on timeout)
    task automatic do_op(input bit rd, input logic [7:0] id, input logic [63:0] data,
                         output int lat, output int exp_lat);
        exp_lat = rd ? 3 + ar_delay + r_delay : 4 + aw_delay + w_delay + b_delay;
`ifdef FD_BRIDGE_CACHE_EN
        if (rd && c_vld && c_tag == id) exp_lat = 1;
`endif
        sb.push_back(rd ? exp_read(id) : 64'h0);
        drive_req(rd, id, data);
        lat = 1;
        while (!C_out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!C_out_valid) lat = -1;
        if (!rd) golden[id] = data;
`ifdef FD_BRIDGE_CACHE_EN
        c_vld = 1; c_tag = id;
`endif
        @(negedge clk);
    endtask

    task automatic clear_cache_model();
`ifdef FD_BRIDGE_CACHE_EN
        c_vld = 0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 0; C_addr = '0; C_data_w = '0; C_in_valid = 0; C_r_wb = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes: got %b expected 000000",
                {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid});
        end
        checks++;
        if (C_data_r !== 64'h0) begin
            failures++; $display("FAIL reset_data_r: got %h expected 0", C_data_r);
        end
        checks++;
        if ({AR_ADDR, AW_ADDR} !== 34'h0) begin
            failures++; $display("FAIL reset_addr: got %h/%h expected 0/0", AR_ADDR, AW_ADDR);
        end
        checks++;
        if (W_DATA !== 64'h0) begin
            failures++; $display("FAIL reset_wdata: got %h expected 0", W_DATA);
        end
        clear_cache_model();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        int lat, el, ar0;
        ar0 = ar_count;
        do_op(1, 8'h05, 64'h0, lat, el);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL read_latency: got %0d expected 3", lat); end
        checks++;
        if (last_ar_addr !== 17'h10028) begin
            failures++; $display("FAIL read_ar_addr: got %h expected 10028", last_ar_addr);
        end
        checks++;
        if (ar_count - ar0 !== 1) begin
            failures++; $display("FAIL read_ar_count: got %0d expected 1", ar_count - ar0);
        end
        do_op(1, 8'h00, 64'h0, lat, el);
        checks++;
        if (last_ar_addr !== 17'h10000) begin
            failures++; $display("FAIL read_id0_addr: got %h expected 10000", last_ar_addr);
        end
    endtask

    task automatic test_write_wdelay();
        int lat, el, aw0, w0;
        logic [63:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        aw0 = aw_count; w0 = w_count;
        w_delay = 5; w_vcycles = 0; w_unstable = 0;
        do_op(0, 8'hFF, d, lat, el);
        w_delay = 0;
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL write_latency: got %0d expected 9", lat); end
        checks++;
        if (last_aw_addr !== 17'h107F8) begin
            failures++; $display("FAIL write_aw_addr: got %h expected 107f8", last_aw_addr);
        end
        checks++;
        if (w_vcycles !== 6 || w_unstable) begin
            failures++; $display("FAIL write_w_hold: got cycles=%0d unstable=%0d expected 6/0",
                w_vcycles, w_unstable);
        end
        checks++;
        if (last_w_data !== d) begin
            failures++; $display("FAIL write_w_data: got %h expected %h", last_w_data, d);
        end
        checks++;
        if (aw_count - aw0 !== 1 || w_count - w0 !== 1) begin
            failures++; $display("FAIL write_counts: got aw=%0d w=%0d expected 1/1",
                aw_count - aw0, w_count - w0);
        end
        do_op(1, 8'hFF, 64'h0, lat, el);
        checks++;
        if (lat !== el) begin failures++; $display("FAIL readback_latency: got %0d expected %0d", lat, el); end
    endtask

    task automatic test_ar_delay();
        int lat, el, ar0;
        ar0 = ar_count;
        ar_delay = 3; ar_vcycles = 0; ar_unstable = 0;
        do_op(1, 8'h7E, 64'h0, lat, el);
        ar_delay = 0;
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL ar_delay_latency: got %0d expected 6", lat); end
        checks++;
        if (ar_vcycles !== 4 || ar_unstable) begin
            failures++; $display("FAIL ar_hold: got cycles=%0d unstable=%0d expected 4/0",
                ar_vcycles, ar_unstable);
        end
        checks++;
        if (ar_count - ar0 !== 1) begin
            failures++; $display("FAIL ar_single: got %0d expected 1", ar_count - ar0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, el, n, ov_seen;
        r_delay = 4;
        drive_req(1, 8'h22, 64'h0);
        n = 0;
        while (!R_READY && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!R_READY) begin failures++; $display("FAIL reach_rd_r: got R_READY=0 expected 1"); end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid} !== 6'b0 ||
            C_data_r !== 64'h0 || AR_ADDR !== 17'h0) begin
            failures++; $display("FAIL async_reset: got strobes=%b data=%h addr=%h expected all 0",
                {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid}, C_data_r, AR_ADDR);
        end
        repeat (2) @(negedge clk);
        r_delay = 0;
        clear_cache_model();
        rst_n = 1;
        ov_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (C_out_valid || AR_VALID || R_READY) ov_seen++;
        end
        checks++;
        if (ov_seen !== 0) begin
            failures++; $display("FAIL reset_no_completion: got %0d active cycles expected 0", ov_seen);
        end
        do_op(1, 8'h22, 64'h0, lat, el);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_spurious();
        int lat, ar0, aw0, w0;
        bit inj;
        logic [63:0] d;
        d = 64'hFEED_0000_1234_5678;
        ar0 = ar_count; aw0 = aw_count; w0 = w_count;
        b_delay = 3;
        sb.push_back(64'h0);
        drive_req(0, 8'h33, d);
        inj = 0; lat = 1;
        while (!C_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            C_in_valid = 0;
            if (B_READY && !inj) begin
                C_addr = 8'h05; C_r_wb = 1; C_in_valid = 1; inj = 1;
            end
        end
        C_in_valid = 0; C_r_wb = 0;
        golden[8'h33] = d;
`ifdef FD_BRIDGE_CACHE_EN
        c_vld = 1; c_tag = 8'h33;
`endif
        b_delay = 0;
        checks++;
        if (!C_out_valid || lat !== 7) begin
            failures++; $display("FAIL spurious_latency: got %0d expected 7", lat);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (ar_count - ar0 !== 0 || aw_count - aw0 !== 1 || w_count - w0 !== 1) begin
            failures++; $display("FAIL spurious_traffic: got ar=%0d aw=%0d w=%0d expected 0/1/1",
                ar_count - ar0, aw_count - aw0, w_count - w0);
        end
        checks++;
        if (!inj) begin failures++; $display("FAIL spurious_inject: got B_READY never seen expected seen"); end
    endtask

`ifdef FD_BRIDGE_CACHE_EN
    task automatic test_cache();
        int lat, el, ar0;
        do_op(1, 8'h10, 64'h0, lat, el);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL cache_miss_latency: got %0d expected 3", lat); end
        ar0 = ar_count;
        do_op(1, 8'h10, 64'h0, lat, el);
        checks++;
        if (lat !== 1 || ar_count !== ar0) begin
            failures++; $display("FAIL cache_hit: got lat=%0d ar=%0d expected 1/0", lat, ar_count - ar0);
        end
        do_op(0, 8'h10, 64'hCAFE_BABE_0000_0010, lat, el);
        ar0 = ar_count;
        do_op(1, 8'h10, 64'h0, lat, el);
        checks++;
        if (lat !== 1 || ar_count !== ar0) begin
            failures++; $display("FAIL cache_write_hit: got lat=%0d ar=%0d expected 1/0", lat, ar_count - ar0);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int lat, el;
        bit rd;
        logic [7:0] id;
        logic [63:0] d;
        for (int i = 0; i < 12; i++) begin
            rd = (i % 3) != 1;
            id = 8'h40 + 8'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
            b_delay  = $urandom_range(0, 2);
            do_op(rd, id, d, lat, el);
            checks++;
            if (lat !== el) begin
                failures++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, el);
            end
        end
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wdelay();
        test_ar_delay();
        test_reset_mid();
        test_spurious();
`ifdef FD_BRIDGE_CACHE_EN
        test_cache();
`endif
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
